afifo_rd_sched: RTL

Read-side scheduler for the asynchronous FIFO. It shares one FIFO read port among `NumReq` consumers in the `rclk` domain. Grants are round-robin, each grant is a bounded burst, and each consumer gets its own valid/ready handshake. It sits between the FIFO's `r`/`rd`/`rempty` port and the downstream consumers, and it is the only agent allowed to drive the FIFO's `r`.

---
 rtl/afifo_rd_sched_pkg.sv | 11 +
 rtl/afifo_rd_sched_if.sv | 30 +++
 rtl/afifo_rd_sched_rr_pick.sv | 41 ++++
 rtl/afifo_rd_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/afifo_rd_sched_pkg.sv
// Shared types and constants for the async FIFO read-side scheduler.
package afifo_pkg;

   localparam int AFIFO_WIDTH_DEFAULT = 12;

   typedef enum logic {
      Idle = 1'b0,
      Xfer = 1'b1
   } rd_state_e;

endpackage

// File: rtl/afifo_rd_sched_if.sv
// Bundle of the FIFO read port and the per-consumer handshakes.
// master: the scheduler. slave: the FIFO plus the consumers.
interface afifo_rd_sched_if
   import afifo_pkg::*;
#(
   parameter int Width  = AFIFO_WIDTH_DEFAULT,
   parameter int NumReq = 2
);

   logic              rempty;
   logic [Width-1:0]  rd;
   logic              r;
   logic [NumReq-1:0] req;
   logic [NumReq-1:0] ready;
   logic [NumReq-1:0] valid;
   logic [Width-1:0]  data;
   logic [NumReq-1:0] grant;
   logic              seqerr;

   modport master (
      input  rempty, rd, req, ready,
      output r, valid, data, grant, seqerr
   );

   modport slave (
      output rempty, rd, req, ready,
      input  r, valid, data, grant, seqerr
   );

endinterface

// File: rtl/afifo_rd_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at NumReq. Returns the one-hot pick and its index.
module afifo_rr_pick #(
   parameter int NumReq = 2
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] ptr_i,
   output logic [NumReq-1:0]         pick_o,
   output logic [$clog2(NumReq)-1:0] idx_o
);

   localparam int IdxW = $clog2(NumReq);

   logic            found_w;
   logic [IdxW-1:0] cand_w;

   // Index ptr+off folded back into 0..NumReq-1.
   function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NumReq) sum = sum - NumReq;
      return IdxW'(sum);
   endfunction

   // Scan candidates in priority order starting at the pointer.
   always_comb begin
      pick_o  = '0;
      idx_o   = '0;
      found_w = 1'b0;
      cand_w  = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand_w = wrap_add(ptr_i, i);
         if (!found_w && req_i[cand_w]) begin
            found_w        = 1'b1;
            pick_o[cand_w] = 1'b1;
            idx_o          = cand_w;
         end
      end
   end

endmodule

// File: rtl/afifo_rd_sched.sv
// Read-side scheduler: shares one FIFO read port among NumReq consumers
// with round-robin grants of at most BurstLen beats each.
// Optional build macro AFIFO_RD_SEQCHK_EN adds a sticky check that popped
// words form a +1 sequence; on a break the pop path is shut off.
module afifo_rd_sched
   import afifo_pkg::*;
#(
   parameter int Width    = AFIFO_WIDTH_DEFAULT,
   parameter int NumReq   = 2,
   parameter int BurstLen = 4
) (
   input logic             rclk,
   input logic             dirclr,
   afifo_rd_sched_if.master bus
);

   localparam int PtrW = $clog2(NumReq);
   localparam int CntW = $clog2(BurstLen + 1);
   localparam logic [CntW-1:0] LastBeat = CntW'(BurstLen - 1);

   rd_state_e         state_q, state_d;
   logic [PtrW-1:0]   g_q, g_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NumReq-1:0] grant_q, grant_d;

   logic [NumReq-1:0] pick_oh;
   logic [PtrW-1:0]   pick_idx;
   logic [NumReq-1:0] valid_w;
   logic              pop_w;
   logic              hold_w;

   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] i);
      if (i == PtrW'(NumReq - 1)) return '0;
      return i + PtrW'(1);
   endfunction

   afifo_rr_pick #(.NumReq(NumReq)) u_pick (
      .req_i  (bus.req),
      .ptr_i  (ptr_q),
      .pick_o (pick_oh),
      .idx_o  (pick_idx)
   );

   // Only the owner sees valid, and only while the FIFO has a word; a pop is
   // the owner's handshake, so other consumers' ready bits never matter.
   assign valid_w    = (state_q == Xfer && !bus.rempty && !hold_w) ? grant_q : '0;
   assign pop_w      = |(valid_w & bus.ready);
   assign bus.r      = pop_w;
   assign bus.valid  = valid_w;
   assign bus.data   = bus.rd;
   assign bus.grant  = grant_q;

   // Next-state: grant from Idle, count beats in Xfer, release on burst end
   // or when the owner drops its request at an edge without a beat.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      case (state_q)
         Idle: begin
            if (|bus.req) begin
               state_d = Xfer;
               g_d     = pick_idx;
               cnt_d   = '0;
               grant_d = pick_oh;
            end
         end
         Xfer: begin
            if (pop_w) begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == LastBeat) begin
                  state_d = Idle;
                  ptr_d   = wrap_inc(g_q);
                  grant_d = '0;
               end
            end else if (!bus.req[g_q]) begin
               state_d = Idle;
               ptr_d   = wrap_inc(g_q);
               grant_d = '0;
            end
         end
         default: begin
            state_d = Idle;
            grant_d = '0;
         end
      endcase
   end

   // Scheduler state; dirclr clears it immediately, which also drops r.
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         state_q <= Idle;
         g_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

`ifdef AFIFO_RD_SEQCHK_EN
   logic [Width-1:0] last_q;
   logic             have_q;
   logic             seqerr_q;

   // Compare each popped word with its predecessor; the first pop after
   // reset only seeds the baseline. An error latches until dirclr.
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         last_q   <= '0;
         have_q   <= 1'b0;
         seqerr_q <= 1'b0;
      end else if (pop_w) begin
         have_q <= 1'b1;
         last_q <= bus.rd;
         if (have_q && bus.rd != last_q + Width'(1)) seqerr_q <= 1'b1;
      end
   end

   assign hold_w     = seqerr_q;
   assign bus.seqerr = seqerr_q;
`else
   assign hold_w     = 1'b0;
   assign bus.seqerr = 1'b0;
`endif

endmodule
